// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants and helpers for the register-file write-back controller.
// Source indices select the producer's slice of the packed request buses.
package regfile_pkg;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREQ = 3;

   localparam int SRC_ALU = 0;
   localparam int SRC_LSU = 1;
   localparam int SRC_MDU = 2;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   // Bit 0 is skipped because $0 can never be busy.
   function automatic logic [5:0] count_busy(input logic [31:0] bits);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 1; i < 32; i++) begin
         cnt = cnt + {5'd0, bits[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first valid source at or after the pointer,
// and moves the pointer just past the winner whenever a grant is issued.
module rr_arbiter #(
   parameter int NREQ = 3,
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   grant_idx,
   output logic            grant_any
);

   logic [PW-1:0] rr_ptr;

   always_comb begin
      logic [PW:0] slot;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      slot      = '0;
      for (int k = 0; k < NREQ; k++) begin
         slot = {1'b0, rr_ptr} + (PW+1)'(k);
         if (slot >= (PW+1)'(NREQ)) begin
            slot = slot - (PW+1)'(NREQ);
         end
         if (!grant_any && req_valid[slot[PW-1:0]]) begin
            grant[slot[PW-1:0]] = 1'b1;
            grant_idx           = slot[PW-1:0];
            grant_any           = 1'b1;
         end
      end
   end

   // A grant always lands on a valid source, so every grant is a transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr <= '0;
      end else if (grant_any) begin
         rr_ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
      end
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates producers onto the register file's single
// write port and tracks in-flight destinations so decode can stall on them.
module regfile_wb_ctrl #(
   parameter int NREQ = regfile_pkg::NREQ,
   parameter int AW   = regfile_pkg::AW,
   parameter int DW   = regfile_pkg::DW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [AW*NREQ-1:0] req_waddr,
   input  logic [DW*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]    req_ready,
   output logic               we,
   output logic [AW-1:0]      waddr,
   output logic [DW-1:0]      wdata,
   input  logic               sb_set,
   input  logic [AW-1:0]      sb_addr,
   input  logic               re1,
   input  logic [AW-1:0]      raddr1,
   input  logic               re2,
   input  logic [AW-1:0]      raddr2,
   output logic               stall,
   output logic               sb_err,
   output logic [5:0]         busy_cnt
);
   import regfile_pkg::*;

   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int NREG = 1 << AW;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx;
   logic            grant_any;
   logic [AW-1:0]   sel_waddr;
   logic [DW-1:0]   sel_wdata;
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic            sb_conflict;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign req_ready = grant;

   always_comb begin
      int gi;
      gi        = int'(grant_idx);
      sel_waddr = req_waddr[AW*gi +: AW];
      sel_wdata = req_wdata[DW*gi +: DW];
   end

   // Writes to $0 are accepted from the producer but never reach the file.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we    <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else if (grant_any) begin
         we    <= (sel_waddr != REG_ZERO);
         waddr <= sel_waddr;
         wdata <= sel_wdata;
      end else begin
         we    <= 1'b0;
      end
   end

   // The set is applied after the clear so a new producer wins a same-cycle race.
   always_comb begin
      busy_next   = busy;
      sb_conflict = 1'b0;
      if (we) begin
         busy_next[waddr] = 1'b0;
      end
      if (sb_set && (sb_addr != REG_ZERO)) begin
         sb_conflict        = busy[sb_addr] && !(we && (waddr == sb_addr));
         busy_next[sb_addr] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy     <= '0;
         busy_cnt <= '0;
         sb_err   <= 1'b0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= count_busy(busy_next);
         if (sb_conflict) begin
            sb_err <= 1'b1;
         end
      end
   end

   // A register committing this cycle is forwarded by the file, so it does not stall.
   assign stall = (re1 && busy[raddr1] && !(we && (waddr == raddr1))) ||
                  (re2 && busy[raddr2] && !(we && (waddr == raddr2)));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed vector table, reset corner case,
// then constrained-random traffic checked against a behavioural model.
module tb_regfile_wb_ctrl;
   import regfile_pkg::*;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [AW*NREQ-1:0]  req_waddr;
   logic [DW*NREQ-1:0]  req_wdata;
   logic [NREQ-1:0]     req_ready;
   logic                we;
   logic [AW-1:0]       waddr;
   logic [DW-1:0]       wdata;
   logic                sb_set;
   logic [AW-1:0]       sb_addr;
   logic                re1, re2;
   logic [AW-1:0]       raddr1, raddr2;
   logic                stall;
   logic                sb_err;
   logic [5:0]          busy_cnt;

   int checks = 0;
   int errors = 0;

   regfile_wb_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_waddr(req_waddr), .req_wdata(req_wdata),
      .req_ready(req_ready),
      .we(we), .waddr(waddr), .wdata(wdata),
      .sb_set(sb_set), .sb_addr(sb_addr),
      .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
      .stall(stall), .sb_err(sb_err), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]       valid;
      logic [2:0][4:0]  a;
      logic [2:0][31:0] d;
      logic             set;
      logic [4:0]       saddr;
      logic             re;
      logic [4:0]       ra;
      logic [2:0]       e_ready;
      logic             e_stall;
      logic             e_we;
      logic [4:0]       e_waddr;
      logic [31:0]      e_wdata;
      logic [5:0]       e_cnt;
      logic             e_err;
   } vec_t;

   vec_t tbl[21];

   // Behavioural model state
   int         m_ptr;
   bit [31:0]  m_busy;
   bit         m_err;
   bit         m_we;
   logic [4:0] m_waddr;
   logic [31:0] m_wdata;

   bit          pend[3];
   logic [4:0]  pa[3];
   logic [31:0] pd[3];
   int          wait_cyc[3];
   int          max_wait;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req_valid = '0; req_waddr = '0; req_wdata = '0;
      sb_set = 1'b0; sb_addr = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      m_ptr = 0; m_busy = '0; m_err = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
      for (int i = 0; i < 3; i++) begin pend[i] = 0; wait_cyc[i] = 0; end
   endtask

   task automatic apply_stimulus(input vec_t v);
      req_valid = v.valid;
      req_waddr = v.a;
      req_wdata = v.d;
      sb_set    = v.set;
      sb_addr   = v.saddr;
      re1       = v.re;
      raddr1    = v.ra;
      re2       = 1'b0;
      raddr2    = '0;
   endtask

   task automatic check_output(input vec_t v, input int row);
      @(negedge clk);
      check($sformatf("row%0d ready", row), 64'(req_ready), 64'(v.e_ready));
      check($sformatf("row%0d stall", row), 64'(stall), 64'(v.e_stall));
      @(posedge clk);
      #1;
      check($sformatf("row%0d we", row), 64'(we), 64'(v.e_we));
      check($sformatf("row%0d waddr", row), 64'(waddr), 64'(v.e_waddr));
      check($sformatf("row%0d wdata", row), 64'(wdata), 64'(v.e_wdata));
      check($sformatf("row%0d busy_cnt", row), 64'(busy_cnt), 64'(v.e_cnt));
      check($sformatf("row%0d sb_err", row), 64'(sb_err), 64'(v.e_err));
   endtask

   function automatic int first_valid(input logic [2:0] v, input int ptr);
      for (int k = 0; k < 3; k++) begin
         if (v[(ptr + k) % 3]) return (ptr + k) % 3;
      end
      return -1;
   endfunction

   function automatic bit read_blocked(input logic re, input logic [4:0] ra);
      return re && m_busy[ra] && !(m_we && m_waddr == ra);
   endfunction

   task automatic random_cycle(input int cyc);
      int         s;
      logic [2:0] exp_ready;
      bit         old_we;
      logic [4:0] old_waddr;
      int         cnt;
      logic [2:0] took;
      for (int i = 0; i < 3; i++) begin
         if (!pend[i] && $urandom_range(0, 2) != 0) begin
            pend[i] = 1;
            pa[i]   = 5'($urandom_range(0, 7));
            pd[i]   = $urandom;
         end
         req_valid[i]          = pend[i];
         req_waddr[5*i +: 5]   = pa[i];
         req_wdata[32*i +: 32] = pd[i];
      end
      sb_addr = 5'($urandom_range(0, 7));
      sb_set  = ($urandom_range(0, 3) == 0);
      if (sb_set && m_busy[sb_addr] && $urandom_range(0, 15) != 0) sb_set = 1'b0;
      re1 = 1'($urandom_range(0, 1)); raddr1 = 5'($urandom_range(0, 7));
      re2 = 1'($urandom_range(0, 1)); raddr2 = 5'($urandom_range(0, 7));

      s = first_valid(req_valid, m_ptr);
      exp_ready = (s >= 0) ? (3'b001 << s) : 3'b000;
      @(negedge clk);
      check($sformatf("rnd%0d ready", cyc), 64'(req_ready), 64'(exp_ready));
      check($sformatf("rnd%0d stall", cyc), 64'(stall),
            64'(read_blocked(re1, raddr1) || read_blocked(re2, raddr2)));
      took = req_valid & req_ready;
      for (int i = 0; i < 3; i++) begin
         if (req_valid[i] && !req_ready[i]) wait_cyc[i]++;
         else wait_cyc[i] = 0;
         if (wait_cyc[i] > max_wait) max_wait = wait_cyc[i];
      end

      old_we = m_we; old_waddr = m_waddr;
      if (s >= 0) begin
         m_we = (pa[s] != 0); m_waddr = pa[s]; m_wdata = pd[s];
         m_ptr = (s + 1) % 3;
      end else begin
         m_we = 0;
      end
      if (sb_set && sb_addr != 0 && m_busy[sb_addr] && !(old_we && old_waddr == sb_addr)) m_err = 1;
      if (old_we) m_busy[old_waddr] = 0;
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1;
      cnt = 0;
      for (int r = 1; r < 32; r++) cnt += int'(m_busy[r]);
      for (int i = 0; i < 3; i++) if (took[i]) pend[i] = 0;

      @(posedge clk);
      #1;
      check($sformatf("rnd%0d we", cyc), 64'(we), 64'(m_we));
      check($sformatf("rnd%0d waddr", cyc), 64'(waddr), 64'(m_waddr));
      check($sformatf("rnd%0d wdata", cyc), 64'(wdata), 64'(m_wdata));
      check($sformatf("rnd%0d busy_cnt", cyc), 64'(busy_cnt), 64'(cnt));
      check($sformatf("rnd%0d sb_err", cyc), 64'(sb_err), 64'(m_err));
   endtask

   initial begin
      tbl[0]  = '{3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 6'd0, 1'b0};
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = '{3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h12345678}, 1'b0, 5'd0, 1'b0, 5'd0,
                  3'b001, 1'b0, 1'b1, 5'd5, 32'h12345678, 6'd0, 1'b0};
      tbl[4]  = '{3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd5, 32'h12345678, 6'd0, 1'b0};
      tbl[5]  = '{3'b100, 15'd0, {32'hDEAD, 32'h0, 32'h0}, 1'b0, 5'd0, 1'b0, 5'd0,
                  3'b100, 1'b0, 1'b0, 5'd0, 32'hDEAD, 6'd0, 1'b0};
      tbl[6]  = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hC2, 32'hB1, 32'hA0}, 1'b0, 5'd0, 1'b0, 5'd0,
                  3'b001, 1'b0, 1'b1, 5'd1, 32'hA0, 6'd0, 1'b0};
      tbl[7]  = tbl[6]; tbl[7].e_ready = 3'b010; tbl[7].e_waddr = 5'd2; tbl[7].e_wdata = 32'hB1;
      tbl[8]  = tbl[6]; tbl[8].e_ready = 3'b100; tbl[8].e_waddr = 5'd3; tbl[8].e_wdata = 32'hC2;
      tbl[9]  = tbl[6];
      tbl[10] = '{3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd1, 32'hA0, 6'd1, 1'b0};
      tbl[11] = '{3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 5'd7, 3'b000, 1'b1, 1'b0, 5'd1, 32'hA0, 6'd1, 1'b0};
      tbl[12] = '{3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h777, 32'h0}, 1'b0, 5'd0, 1'b1, 5'd7,
                  3'b010, 1'b1, 1'b1, 5'd7, 32'h777, 6'd1, 1'b0};
      tbl[13] = '{3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 5'd7, 3'b000, 1'b0, 1'b0, 5'd7, 32'h777, 6'd0, 1'b0};
      tbl[14] = tbl[13];
      tbl[15] = '{3'b000, 15'd0, 96'd0, 1'b1, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd7, 32'h777, 6'd0, 1'b0};
      tbl[16] = '{3'b000, 15'd0, 96'd0, 1'b1, 5'd9, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd7, 32'h777, 6'd1, 1'b0};
      tbl[17] = '{3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h99}, 1'b0, 5'd0, 1'b0, 5'd0,
                  3'b001, 1'b0, 1'b1, 5'd9, 32'h99, 6'd1, 1'b0};
      tbl[18] = '{3'b000, 15'd0, 96'd0, 1'b1, 5'd9, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd9, 32'h99, 6'd1, 1'b0};
      tbl[19] = '{3'b000, 15'd0, 96'd0, 1'b1, 5'd9, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd9, 32'h99, 6'd1, 1'b1};
      tbl[20] = '{3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 5'd9, 3'b000, 1'b1, 1'b0, 5'd9, 32'h99, 6'd1, 1'b1};

      max_wait = 0;
      do_reset();
      for (int r = 0; r < 21; r++) begin
         apply_stimulus(tbl[r]);
         check_output(tbl[r], r);
      end

      // Asynchronous reset while a write sits in the output register
      idle_inputs();
      req_valid = 3'b010; req_waddr = {5'd0, 5'd4, 5'd0}; req_wdata = {32'h0, 32'h44, 32'h0};
      @(negedge clk);
      check("pre_rst ready", 64'(req_ready), 64'(3'b010));
      @(posedge clk);
      #1;
      check("pre_rst we", 64'(we), 64'(1'b1));
      idle_inputs();
      #1 rst = 1'b0;
      #1;
      check("async_rst we", 64'(we), 64'(1'b0));
      check("async_rst waddr", 64'(waddr), 64'(0));
      check("async_rst wdata", 64'(wdata), 64'(0));
      check("async_rst busy_cnt", 64'(busy_cnt), 64'(0));
      check("async_rst sb_err", 64'(sb_err), 64'(0));
      re1 = 1'b1; raddr1 = 5'd9;
      #1;
      check("async_rst stall", 64'(stall), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      req_valid = 3'b111; req_waddr = {5'd3, 5'd2, 5'd1}; req_wdata = {32'hC, 32'hB, 32'hA};
      #1;
      check("post_rst ready", 64'(req_ready), 64'(3'b001));
      @(posedge clk);
      #1;
      check("post_rst waddr", 64'(waddr), 64'(1));
      check("post_rst wdata", 64'(wdata), 64'(32'hA));

      do_reset();
      for (int c = 0; c < 800; c++) random_cycle(c);
      do_reset();
      for (int c = 800; c < 1600; c++) random_cycle(c);
      check("starvation max_wait<NREQ", 64'(max_wait < NREQ), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
